instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Encodes symbolic MIPS instructions (mnemonic + register/immediate/target fields) into 32-bit words.
//  Writes each word sequentially into program memory, for boot-time program loading and for self-checking benches.
//  Inverse of the opcode-to-control decode path: produces the opcode/funct encodings the control unit consumes.
//  Sits between a host/command source and the instruction-memory write port.
// PARAMETERS
//  ADDR_WIDTH  6   word-address width of program memory; DEPTH = 2**ADDR_WIDTH words
//  BASE_ADDR   0   word address of first write; mem_addr = BASE_ADDR + wr_ptr (mod 2**ADDR_WIDTH)
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             asynchronous, active-low reset
//  clear      in   1             synchronous restart: wr_ptr<=0, full<=0, state<=IDLE
//  cmd_valid  in   1             command present
//  cmd_ready  out  1             block can accept a command this cycle
//  cmd_mnem   in   5             0 ADD,1 SUB,2 AND,3 OR,4 NOR,5 SLL,6 SRL,7 JR,8 ADDI,9 ORI,10 ANDI,11 LUI,12 LW,13 SW,14 BEQ,15 BNE,16 J,17 JAL; 18-31 illegal
//  cmd_rs     in   5             rs field
//  cmd_rt     in   5             rt field
//  cmd_rd     in   5             rd field
//  cmd_shamt  in   5             shift amount
//  cmd_imm    in   16            immediate / branch offset
//  cmd_target in   26            jump target
//  mem_we     out  1             program-memory write strobe, one cycle per word
//  mem_addr   out  ADDR_WIDTH    write address
//  mem_wdata  out  32            encoded instruction word
//  word_count out  ADDR_WIDTH+1  words written since reset/clear
//  full       out  1             DEPTH words written; no further commands accepted
//  err_illegal out 1             one-cycle pulse: illegal mnemonic accepted and dropped
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0: mem_we, mem_addr, mem_wdata, word_count, full, err_illegal.
//  Reset applies immediately in any state; an in-flight write is abandoned with mem_we deasserted at once.
//  cmd_ready = (state==IDLE) && !full && !clear.
//  FSM: IDLE, WRITE, FULL.
//   IDLE: on cmd_valid&&cmd_ready at edge N:
//    - Legal mnemonic: encoded word -> mem_wdata, BASE_ADDR+wr_ptr -> mem_addr; state<=WRITE.
//    - Illegal mnemonic: err_illegal=1 for the cycle after N; state stays IDLE; wr_ptr unchanged.
//   WRITE: mem_we=1 for exactly this one cycle (registered output). At the next edge: wr_ptr++;
//    state<=FULL if the new wr_ptr==DEPTH, else IDLE.
//   FULL: full=1, cmd_ready=0; leaves only via clear or reset.
//  Latency and throughput:
//   - Accept edge N -> mem_we high in cycle N+1 -> cmd_ready high again in cycle N+2.
//   - Max throughput: one word per 2 cycles.
//  mem_addr and mem_wdata are held stable while mem_we=1. Outside WRITE they retain their last value.
//  Encoding:
//   - R-type {6'h00,rs,rt,rd,shamt,funct}; funct ADD 20, SUB 22, AND 24, OR 25, NOR 27, SLL 00, SRL 02, JR 08 (hex).
//   - R-type masking: SLL/SRL force rs=0. JR forces rt=rd=shamt=0. Other R-type ops force shamt=0.
//   - I-type {op,rs,rt,imm}; op ADDI 08, ORI 0D, ANDI 0C, LUI 0F, LW 23, SW 2B, BEQ 04, BNE 05 (hex).
//   - I-type masking: LUI forces rs=0.
//   - J-type {op,target}; J 02, JAL 03.
//   - Fields not used by the format are ignored. No sign handling: imm and target are copied verbatim.
//  wr_ptr / word_count:
//   - Width ADDR_WIDTH+1; counts 0..DEPTH and never wraps; word_count = wr_ptr.
//   - mem_addr wraps modulo 2**ADDR_WIDTH when BASE_ADDR+wr_ptr overflows.
//  clear: checked at every edge; has priority over accept.
//   - A write already in cycle WRITE completes (mem_we already high), then wr_ptr<=0, full<=0, state<=IDLE.
//   - clear during an accept edge: the command is not accepted (cmd_ready is 0).
//  err_illegal is never asserted together with mem_we.
// TESTING
//  1 ADD rd=3 rs=1 rt=2 shamt=7 -> mem_we at addr 0, wdata 0x00221820 (shamt masked); word_count=1.
//  2 Back-to-back:
//    - ADDI rt=8 rs=0 imm=0005 -> 0x20080005 at addr 1.
//    - LUI rs=7 rt=1 imm=1001 -> 0x3C011001 at addr 2 (rs masked).
//    - Check cmd_ready low for exactly 1 cycle per accept.
//  3 SW rs=29 rt=9 imm=FFFC -> 0xAFA9FFFC; J target=0100008 -> 0x08100008; JAL same target -> 0x0C100008.
//  4 cmd_mnem=20 -> err_illegal pulse 1 cycle, no mem_we, word_count unchanged; next legal cmd lands at the unchanged address.
//  5 ADDR_WIDTH=2:
//    - 4 legal cmds -> full=1 and cmd_ready=0 after 4th write; 5th cmd_valid ignored.
//    - clear -> full=0, next write at addr 0.
//  6 Reset asserted during WRITE -> mem_we drops asynchronously; all outputs 0; first post-reset write at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS instructions into 32-bit words and writes them
// sequentially into program memory starting at BASE_ADDR.
module instr_encoder_loader #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [4:0]            cmd_mnem,
    input  logic [4:0]            cmd_rs,
    input  logic [4:0]            cmd_rt,
    input  logic [4:0]            cmd_rd,
    input  logic [4:0]            cmd_shamt,
    input  logic [15:0]           cmd_imm,
    input  logic [25:0]           cmd_target,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  full,
    output logic                  err_illegal
);

    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    typedef enum logic [4:0] {
        MN_ADD, MN_SUB, MN_AND, MN_OR, MN_NOR, MN_SLL, MN_SRL, MN_JR,
        MN_ADDI, MN_ORI, MN_ANDI, MN_LUI, MN_LW, MN_SW, MN_BEQ, MN_BNE,
        MN_J, MN_JAL
    } mnem_t;

    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  err_q, err_d;
    logic                  legal;
    logic [31:0]           enc_word;

    always_comb begin
        legal    = 1'b1;
        enc_word = '0;
        case (cmd_mnem)
            MN_ADD:  enc_word = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h20};
            MN_SUB:  enc_word = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h22};
            MN_AND:  enc_word = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h24};
            MN_OR:   enc_word = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h25};
            MN_NOR:  enc_word = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h27};
            MN_SLL:  enc_word = {6'h00, 5'd0, cmd_rt, cmd_rd, cmd_shamt, 6'h00};
            MN_SRL:  enc_word = {6'h00, 5'd0, cmd_rt, cmd_rd, cmd_shamt, 6'h02};
            MN_JR:   enc_word = {6'h00, cmd_rs, 15'd0, 6'h08};
            MN_ADDI: enc_word = {6'h08, cmd_rs, cmd_rt, cmd_imm};
            MN_ORI:  enc_word = {6'h0D, cmd_rs, cmd_rt, cmd_imm};
            MN_ANDI: enc_word = {6'h0C, cmd_rs, cmd_rt, cmd_imm};
            MN_LUI:  enc_word = {6'h0F, 5'd0, cmd_rt, cmd_imm};
            MN_LW:   enc_word = {6'h23, cmd_rs, cmd_rt, cmd_imm};
            MN_SW:   enc_word = {6'h2B, cmd_rs, cmd_rt, cmd_imm};
            MN_BEQ:  enc_word = {6'h04, cmd_rs, cmd_rt, cmd_imm};
            MN_BNE:  enc_word = {6'h05, cmd_rs, cmd_rt, cmd_imm};
            MN_J:    enc_word = {6'h02, cmd_target};
            MN_JAL:  enc_word = {6'h03, cmd_target};
            default: legal    = 1'b0;
        endcase
    end

    assign full      = (state_q == FULL);
    assign cmd_ready = (state_q == IDLE) && !full && !clear;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    wr_ptr_d = '0;
                end else if (cmd_valid && cmd_ready) begin
                    if (legal) begin
                        mem_addr_d  = BASE + wr_ptr_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = enc_word;
                        state_d     = WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                // the strobe is already out this cycle, so clear only rewinds the pointer
                if (clear) begin
                    wr_ptr_d = '0;
                    state_d  = IDLE;
                end else begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    state_d  = (wr_ptr_d == DEPTH_CNT) ? FULL : IDLE;
                end
            end
            FULL: begin
                if (clear) begin
                    wr_ptr_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_we      = (state_q == WRITE);
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign word_count  = wr_ptr_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: a default-size instance plus a 4-word
// instance for fill/clear behaviour, checked against a table-driven model.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_a, clear_b, valid_a, valid_b;
    logic [4:0]  cmd_mnem, cmd_rs, cmd_rt, cmd_rd, cmd_shamt;
    logic [15:0] cmd_imm;
    logic [25:0] cmd_target;

    logic        rdy_a, we_a, full_a, err_a;
    logic [5:0]  addr_a;
    logic [31:0] wdata_a;
    logic [6:0]  wc_a;
    logic        rdy_b, we_b, full_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  wc_b;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cnt [2];
    int unsigned depth [2];
    int          sel = 0;

    logic [31:0] o_rdy, o_we, o_addr, o_wdata, o_wc, o_full, o_err;

    logic [5:0] funct_tab [8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h08};
    logic [5:0] op_tab    [10] = '{6'h08, 6'h0D, 6'h0C, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

    instr_encoder_loader u_dut_a (
        .clk(clk), .reset(reset), .clear(clear_a), .cmd_valid(valid_a), .cmd_ready(rdy_a),
        .cmd_mnem(cmd_mnem), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_shamt(cmd_shamt), .cmd_imm(cmd_imm), .cmd_target(cmd_target),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .word_count(wc_a),
        .full(full_a), .err_illegal(err_a)
    );

    instr_encoder_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) u_dut_b (
        .clk(clk), .reset(reset), .clear(clear_b), .cmd_valid(valid_b), .cmd_ready(rdy_b),
        .cmd_mnem(cmd_mnem), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_shamt(cmd_shamt), .cmd_imm(cmd_imm), .cmd_target(cmd_target),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .word_count(wc_b),
        .full(full_b), .err_illegal(err_b)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (sel == 0) begin
            o_rdy = 32'(rdy_a);  o_we = 32'(we_a);  o_addr = 32'(addr_a);
            o_wdata = wdata_a;   o_wc = 32'(wc_a);  o_full = 32'(full_a); o_err = 32'(err_a);
        end else begin
            o_rdy = 32'(rdy_b);  o_we = 32'(we_b);  o_addr = 32'(addr_b);
            o_wdata = wdata_b;   o_wc = 32'(wc_b);  o_full = 32'(full_b); o_err = 32'(err_b);
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_enc(input logic [4:0] mn, input logic [4:0] rs, rt, rd, sh,
                                            input logic [15:0] imm, input logic [25:0] tgt);
        logic shift, jr;
        shift = (mn == 5'd5) || (mn == 5'd6);
        jr    = (mn == 5'd7);
        if (mn < 5'd8)
            return {6'h00, shift ? 5'd0 : rs, jr ? 5'd0 : rt, jr ? 5'd0 : rd,
                    shift ? sh : 5'd0, funct_tab[mn[2:0]]};
        else if (mn < 5'd16)
            return {op_tab[mn - 5'd8], (mn == 5'd11) ? 5'd0 : rs, rt, imm};
        else
            return {op_tab[mn - 5'd8], tgt};
    endfunction

    task automatic set_fields(input logic [4:0] mn, rs, rt, rd, sh, input logic [15:0] imm,
                              input logic [25:0] tgt);
        cmd_mnem = mn; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
        cmd_shamt = sh; cmd_imm = imm; cmd_target = tgt;
    endtask

    task automatic send(input int s, input logic [4:0] mn, rs, rt, rd, sh, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic [31:0] exp_w);
        int unsigned n = 0;
        sel = s;
        #1;
        while (o_rdy != 32'd1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (o_rdy != 32'd1) begin
            chk_eq("ready_wait", o_rdy, 32'd1);
            return;
        end
        set_fields(mn, rs, rt, rd, sh, imm, tgt);
        if (s == 0) valid_a = 1'b1; else valid_b = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0; valid_b = 1'b0;
        if (mn < 5'd18) begin
            chk_eq("we", o_we, 32'd1);
            chk_eq("addr", o_addr, cnt[s] % depth[s]);
            chk_eq("wdata", o_wdata, exp_w);
            chk_eq("rdy_busy", o_rdy, 32'd0);
            chk_eq("err_quiet", o_err, 32'd0);
            @(posedge clk); #1;
            cnt[s]++;
            chk_eq("we_drop", o_we, 32'd0);
            chk_eq("word_count", o_wc, cnt[s]);
            chk_eq("full", o_full, 32'(cnt[s] == depth[s]));
            chk_eq("rdy_back", o_rdy, 32'(cnt[s] != depth[s]));
        end else begin
            chk_eq("err_pulse", o_err, 32'd1);
            chk_eq("we_illegal", o_we, 32'd0);
            chk_eq("rdy_illegal", o_rdy, 32'd1);
            @(posedge clk); #1;
            chk_eq("err_clear", o_err, 32'd0);
            chk_eq("wc_illegal", o_wc, cnt[s]);
        end
    endtask

    task automatic check_reset_state(input int s);
        sel = s;
        #1;
        chk_eq("rst_we", o_we, 32'd0);
        chk_eq("rst_addr", o_addr, 32'd0);
        chk_eq("rst_wdata", o_wdata, 32'd0);
        chk_eq("rst_wc", o_wc, 32'd0);
        chk_eq("rst_full", o_full, 32'd0);
        chk_eq("rst_err", o_err, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  mn, rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tgt;

        depth[0] = 64; depth[1] = 4;
        cnt[0] = 0;    cnt[1] = 0;
        reset = 1'b0; clear_a = 1'b0; clear_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        set_fields(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_state(0);
        check_reset_state(1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        send(0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0, 32'h00221820);
        send(0, 5'd8, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0, 32'h20080005);
        send(0, 5'd11, 5'd7, 5'd1, 5'd0, 5'd0, 16'h1001, 26'h0, 32'h3C011001);
        send(0, 5'd13, 5'd29, 5'd9, 5'd0, 5'd0, 16'hFFFC, 26'h0, 32'hAFA9FFFC);
        send(0, 5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100008, 32'h08100008);
        send(0, 5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100008, 32'h0C100008);
        send(0, 5'd20, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 32'h0);
        send(0, 5'd9, 5'd3, 5'd4, 5'd0, 5'd0, 16'hBEEF, 26'h0, 32'h3464BEEF);

        // clear while a write is on the bus: the write finishes, pointer rewinds
        sel = 0;
        set_fields(5'd1, 5'd5, 5'd6, 5'd7, 5'd0, 16'h0, 26'h0);
        valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        chk_eq("clrw_we", o_we, 32'd1);
        clear_a = 1'b1;
        @(posedge clk); #1;
        clear_a = 1'b0;
        cnt[0] = 0;
        chk_eq("clrw_we_drop", o_we, 32'd0);
        chk_eq("clrw_wc", o_wc, 32'd0);

        // clear competing with a valid command in IDLE blocks the accept
        clear_a = 1'b1;
        valid_a = 1'b1;
        #1;
        chk_eq("clr_rdy", o_rdy, 32'd0);
        @(posedge clk); #1;
        clear_a = 1'b0;
        valid_a = 1'b0;
        chk_eq("clr_no_we", o_we, 32'd0);
        chk_eq("clr_no_err", o_err, 32'd0);
        send(0, 5'd2, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 26'h0, 32'h00221824);

        repeat (40) begin
            mn = 5'($urandom_range(0, 31));
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
            imm = 16'($urandom); tgt = 26'($urandom);
            send(0, mn, rs, rt, rd, sh, imm, tgt, ref_enc(mn, rs, rt, rd, sh, imm, tgt));
        end

        // small instance: fill to DEPTH, ignore further commands, then clear
        for (int i = 0; i < 4; i++) begin
            mn = 5'($urandom_range(0, 17));
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
            imm = 16'($urandom); tgt = 26'($urandom);
            send(1, mn, rs, rt, rd, sh, imm, tgt, ref_enc(mn, rs, rt, rd, sh, imm, tgt));
        end
        sel = 1;
        set_fields(5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
        valid_b = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk_eq("full_no_we", o_we, 32'd0);
        end
        valid_b = 1'b0;
        chk_eq("full_hold", o_full, 32'd1);
        chk_eq("full_rdy", o_rdy, 32'd0);
        chk_eq("full_wc", o_wc, 32'd4);
        clear_b = 1'b1;
        @(posedge clk); #1;
        clear_b = 1'b0;
        cnt[1] = 0;
        chk_eq("clr_full", o_full, 32'd0);
        chk_eq("clr_wc", o_wc, 32'd0);
        send(1, 5'd12, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0010, 26'h0, 32'h8C430010);

        // reset during WRITE drops the strobe without waiting for a clock edge
        sel = 0;
        set_fields(5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        chk_eq("pre_rst_we", o_we, 32'd1);
        #2;
        reset = 1'b0;
        check_reset_state(0);
        check_reset_state(1);
        @(posedge clk); #1;
        reset = 1'b1;
        cnt[0] = 0; cnt[1] = 0;
        send(0, 5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221827);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
